// File: rtl/vend_stim_if.sv
// Bundle between a table-loading host and the vend_stim_seq playback engine:
// table writes and playback control in, status and vending-machine phase outputs back.
interface vend_stim_if #(
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_product;
    logic [DATA_W-1:0] wr_money;
    logic              clear_tab;
    logic              start;
    logic              loop_mode;
    logic              abort;
    logic              full;
    logic              busy;
    logic              done;
    logic [7:0]        txn_count;
    logic              escolher;
    logic              inserir_dinheiro;
    logic              dar_troco;
    logic [DATA_W-1:0] produto_escolhido;
    logic [DATA_W-1:0] dinheiro_inserido;

    modport master (
        output wr_en, wr_product, wr_money, clear_tab, start, loop_mode, abort,
        input  full, busy, done, txn_count, escolher, inserir_dinheiro, dar_troco,
        input  produto_escolhido, dinheiro_inserido
    );

    modport slave (
        input  wr_en, wr_product, wr_money, clear_tab, start, loop_mode, abort,
        output full, busy, done, txn_count, escolher, inserir_dinheiro, dar_troco,
        output produto_escolhido, dinheiro_inserido
    );
endinterface

// File: rtl/vend_stim_seq.sv
// Vending-machine stimulus sequencer: replays a table of (product, money) entries
// as CLEAR/CHOOSE/INSERT/CHANGE phases, each held HOLD cycles, with registered outputs.
module vend_stim_seq #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int HOLD   = 1
) (
    input  logic     clock,
    input  logic     reset_n,
    vend_stim_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, CHOOSE, INSERT, CHANGE} state_t;

    state_t            state, state_nx;
    logic [AW:0]       count, count_nx;
    logic [AW-1:0]     idx, idx_nx;
    logic [HW-1:0]     hold, hold_nx;
    logic [7:0]        txn, txn_nx;
    logic              full_r, busy_r, done_r, done_nx;
    logic              esc_r, esc_nx, ins_r, ins_nx, chg_r, chg_nx;
    logic [DATA_W-1:0] prod_r, prod_nx, money_r, money_nx;
    logic              mem_we;
    logic [DATA_W-1:0] mem_prod  [DEPTH];
    logic [DATA_W-1:0] mem_money [DEPTH];

    // Table storage is not reset; only the entry count defines valid contents.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_prod[count[AW-1:0]]  <= bus.wr_product;
            mem_money[count[AW-1:0]] <= bus.wr_money;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        idx_nx   = idx;
        hold_nx  = hold;
        txn_nx   = txn;
        done_nx  = 1'b0;
        mem_we   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clear_tab) begin
                    count_nx = '0;
                end else if (bus.wr_en && !full_r) begin
                    mem_we   = 1'b1;
                    count_nx = count + 1'b1;
                end
                if (bus.start && count_nx != '0) begin
                    state_nx = CLEAR;
                    idx_nx   = '0;
                    hold_nx  = '0;
                end
            end
            default: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    hold_nx  = '0;
                end else if (hold != HW'(HOLD - 1)) begin
                    hold_nx = hold + 1'b1;
                end else begin
                    hold_nx = '0;
                    case (state)
                        CLEAR:  state_nx = CHOOSE;
                        CHOOSE: state_nx = INSERT;
                        INSERT: state_nx = CHANGE;
                        default: begin
                            txn_nx = txn + 8'd1;
                            if ({1'b0, idx} < count - 1'b1) begin
                                state_nx = CLEAR;
                                idx_nx   = idx + 1'b1;
                            end else if (bus.loop_mode) begin
                                state_nx = CLEAR;
                                idx_nx   = '0;
                            end else begin
                                state_nx = IDLE;
                                idx_nx   = '0;
                                done_nx  = 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase

        // Output registers are loaded with the values belonging to the state being entered.
        esc_nx   = 1'b0;
        ins_nx   = 1'b0;
        chg_nx   = 1'b0;
        prod_nx  = prod_r;
        money_nx = money_r;
        case (state_nx)
            CHOOSE: begin
                esc_nx   = 1'b1;
                prod_nx  = mem_prod[idx_nx];
                money_nx = '0;
            end
            INSERT: begin
                ins_nx   = 1'b1;
                money_nx = mem_money[idx_nx];
            end
            CHANGE: chg_nx = 1'b1;
            default: begin
                prod_nx  = '0;
                money_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            count   <= '0;
            idx     <= '0;
            hold    <= '0;
            txn     <= '0;
            full_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            esc_r   <= 1'b0;
            ins_r   <= 1'b0;
            chg_r   <= 1'b0;
            prod_r  <= '0;
            money_r <= '0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            idx     <= idx_nx;
            hold    <= hold_nx;
            txn     <= txn_nx;
            full_r  <= (count_nx == (AW + 1)'(DEPTH));
            busy_r  <= (state_nx != IDLE);
            done_r  <= done_nx;
            esc_r   <= esc_nx;
            ins_r   <= ins_nx;
            chg_r   <= chg_nx;
            prod_r  <= prod_nx;
            money_r <= money_nx;
        end
    end

    assign bus.full              = full_r;
    assign bus.busy              = busy_r;
    assign bus.done              = done_r;
    assign bus.txn_count         = txn;
    assign bus.escolher          = esc_r;
    assign bus.inserir_dinheiro  = ins_r;
    assign bus.dar_troco         = chg_r;
    assign bus.produto_escolhido = prod_r;
    assign bus.dinheiro_inserido = money_r;
endmodule
